// File: rtl/axi_read_responder.sv
// AXI4 read responder over a 64-bit word store, one burst at a time, with a preload write port.
// Latency: first beat 1 cycle after AR; READ_LATENCY cycles when AXI_RD_LATENCY_EN is defined.
// Backpressure: rdata/rresp/rlast hold while rvalid && !rready; arready only when idle.
module axi_read_responder #(
    parameter int          MEM_WORDS    = 4096,
    parameter logic [63:0] MEM_BASE     = 64'h0,
    parameter int          READ_LATENCY = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [63:0] s_axi_araddr,
    input  logic [7:0]  s_axi_arlen,
    input  logic [2:0]  s_axi_arsize,
    input  logic [1:0]  s_axi_arburst,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [63:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rlast,
    input  logic        mem_we,
    input  logic [63:0] mem_waddr,
    input  logic [63:0] mem_wdata
);

    localparam int          AW       = $clog2(MEM_WORDS);
    localparam logic [63:0] MEM_SPAN = 64'(MEM_WORDS) << 3;

`ifdef AXI_RD_LATENCY_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BEAT = 2'd1, S_WAIT = 2'd2} state_t;
    localparam bit          USE_WAIT = (READ_LATENCY > 1);
    localparam logic [15:0] LAT_LOAD = USE_WAIT ? 16'(READ_LATENCY - 2) : 16'd0;
    logic [15:0] lat_q;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BEAT = 2'd1} state_t;
    localparam int unused_read_latency = READ_LATENCY;
`endif

    state_t      state_q, state_d;
    logic [63:0] addr_q;
    logic [7:0]  len_q;
    logic [7:0]  cnt_q;
    logic [2:0]  size_q;
    logic [1:0]  burst_q;
    logic        berr_q;

    logic [63:0] mem [MEM_WORDS];

    logic        ar_hs;
    logic        r_hs;
    logic        ar_berr;
    logic [63:0] beat_bytes;
    logic [63:0] wrap_bytes;
    logic [63:0] wrap_base;
    logic [63:0] incr_addr;
    logic [63:0] addr_nxt;
    logic        load;
    logic [63:0] fetch_addr;
    logic        fetch_berr;
    logic [63:0] fetch_off;
    logic        fetch_err;
    logic [AW-1:0] fetch_idx;
    logic [63:0] woff;
    logic [AW-1:0] widx;

    assign s_axi_arready = (state_q == S_IDLE);
    assign s_axi_rvalid  = (state_q == S_BEAT);
    assign s_axi_rlast   = s_axi_rvalid && (cnt_q == len_q);
    assign ar_hs         = s_axi_arvalid && s_axi_arready;
    assign r_hs          = s_axi_rvalid && s_axi_rready;

    // Errors that poison every beat of the burst are decided once at AR time.
    always_comb begin
        ar_berr = 1'b0;
        if (s_axi_arsize > 3'd3 || s_axi_arburst == 2'd3) begin
            ar_berr = 1'b1;
        end else if (s_axi_arburst == 2'd2) begin
            case (s_axi_arlen)
                8'd1, 8'd3, 8'd7, 8'd15: ar_berr = 1'b0;
                default:                 ar_berr = 1'b1;
            endcase
        end
    end

    always_comb begin
        beat_bytes = 64'd1 << size_q;
        wrap_bytes = ({56'd0, len_q} + 64'd1) << size_q;
        wrap_base  = addr_q & ~(wrap_bytes - 64'd1);
        incr_addr  = addr_q + beat_bytes;
        case (burst_q)
            2'd1:    addr_nxt = incr_addr;
            2'd2:    addr_nxt = (incr_addr == wrap_base + wrap_bytes) ? wrap_base : incr_addr;
            default: addr_nxt = addr_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state plus selection of which address the output register fetches.
    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        fetch_addr = addr_q;
        fetch_berr = berr_q;
        case (state_q)
            S_IDLE: begin
                if (ar_hs) begin
                    state_d    = S_BEAT;
                    load       = 1'b1;
                    fetch_addr = s_axi_araddr;
                    fetch_berr = ar_berr;
`ifdef AXI_RD_LATENCY_EN
                    if (USE_WAIT) begin
                        state_d = S_WAIT;
                        load    = 1'b0;
                    end
`endif
                end
            end
`ifdef AXI_RD_LATENCY_EN
            S_WAIT: begin
                if (lat_q == 16'd0) begin
                    state_d = S_BEAT;
                    load    = 1'b1;
                end
            end
`endif
            S_BEAT: begin
                if (r_hs) begin
                    if (s_axi_rlast) begin
                        state_d = S_IDLE;
                    end else begin
                        load       = 1'b1;
                        fetch_addr = addr_nxt;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Offset wraps to a huge value below MEM_BASE, so one compare covers both bounds.
    assign fetch_off = fetch_addr - MEM_BASE;
    assign fetch_err = fetch_berr || (fetch_off >= MEM_SPAN);
    assign fetch_idx = fetch_off[3 +: AW];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q      <= 64'd0;
            len_q       <= 8'd0;
            cnt_q       <= 8'd0;
            size_q      <= 3'd0;
            burst_q     <= 2'd0;
            berr_q      <= 1'b0;
            s_axi_rdata <= 64'd0;
            s_axi_rresp <= 2'b00;
        end else begin
            if (ar_hs) begin
                addr_q  <= s_axi_araddr;
                len_q   <= s_axi_arlen;
                size_q  <= s_axi_arsize;
                burst_q <= s_axi_arburst;
                berr_q  <= ar_berr;
                cnt_q   <= 8'd0;
            end else if (r_hs) begin
                addr_q <= addr_nxt;
                cnt_q  <= cnt_q + 8'd1;
            end
            if (load) begin
                s_axi_rdata <= fetch_err ? 64'd0 : mem[fetch_idx];
                s_axi_rresp <= fetch_err ? 2'b10 : 2'b00;
            end
        end
    end

`ifdef AXI_RD_LATENCY_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lat_q <= 16'd0;
        end else if (ar_hs) begin
            lat_q <= LAT_LOAD;
        end else if (state_q == S_WAIT && lat_q != 16'd0) begin
            lat_q <= lat_q - 16'd1;
        end
    end
`endif

    // Preload port; a same-edge fetch of this word still sees the old contents.
    assign woff = mem_waddr - MEM_BASE;
    assign widx = woff[3 +: AW];

    always_ff @(posedge clock) begin
        if (mem_we && woff < MEM_SPAN) begin
            mem[widx] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_axi_read_responder.sv
// Directed bench for axi_read_responder: a scoreboard queue is filled at AR time and drained on R handshakes.
module tb_axi_read_responder;

    localparam int          MEM_WORDS = 4096;
    localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) * 64'd8;
`ifdef AXI_RD_LATENCY_EN
    localparam int EXP_LAT = 4;
`else
    localparam int EXP_LAT = 1;
`endif

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [63:0] s_axi_araddr = 64'd0;
    logic [7:0]  s_axi_arlen = 8'd0;
    logic [2:0]  s_axi_arsize = 3'd0;
    logic [1:0]  s_axi_arburst = 2'd0;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        mem_we = 1'b0;
    logic [63:0] mem_waddr = 64'd0;
    logic [63:0] mem_wdata = 64'd0;

    always #5 clock = ~clock;

    axi_read_responder #(
        .MEM_WORDS   (MEM_WORDS),
        .MEM_BASE    (64'h0),
        .READ_LATENCY(4)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready),
        .s_axi_araddr (s_axi_araddr),
        .s_axi_arlen  (s_axi_arlen),
        .s_axi_arsize (s_axi_arsize),
        .s_axi_arburst(s_axi_arburst),
        .s_axi_rvalid (s_axi_rvalid),
        .s_axi_rready (s_axi_rready),
        .s_axi_rdata  (s_axi_rdata),
        .s_axi_rresp  (s_axi_rresp),
        .s_axi_rlast  (s_axi_rlast),
        .mem_we       (mem_we),
        .mem_waddr    (mem_waddr),
        .mem_wdata    (mem_wdata)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [63:0] shadow [MEM_WORDS];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference burst walk: wrap base found by division rather than masking.
    task automatic push_burst(input logic [63:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
        logic [63:0] a, bytes, wb, base;
        logic        berr, err;
        beat_t       b;
        berr  = (size > 3'd3) || (burst == 2'd3) ||
                (burst == 2'd2 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
        a     = addr;
        bytes = 64'd1 << size;
        wb    = (64'(len) + 64'd1) * bytes;
        base  = (a / wb) * wb;
        for (int i = 0; i <= int'(len); i++) begin
            err    = berr || (a >= MEM_BYTES);
            b.data = 64'd0;
            if (!err) b.data = shadow[int'(a >> 3)];
            b.resp = err ? 2'b10 : 2'b00;
            b.last = (i == int'(len));
            exp_q.push_back(b);
            if (burst == 2'd1) begin
                a = a + bytes;
            end else if (burst == 2'd2) begin
                a = a + bytes;
                if (a == base + wb) a = base;
            end
        end
    endtask

    task automatic send_ar(input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int lat;
        push_burst(addr, len, size, burst);
        @(negedge clock);
        s_axi_arvalid = 1'b1;
        s_axi_araddr  = addr;
        s_axi_arlen   = len;
        s_axi_arsize  = size;
        s_axi_arburst = burst;
        chk("arready_idle", 64'(s_axi_arready), 64'd1);
        @(negedge clock);
        s_axi_arvalid = 1'b0;
        lat = 1;
        while (!s_axi_rvalid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        chk("first_beat_latency", 64'(lat), 64'(EXP_LAT));
    endtask

    // mode 0: rready always high; mode 1: rready pattern 1,0,0,1.
    task automatic collect(input int mode, input int max_hs);
        int    cyc;
        int    hs;
        logic  done;
        beat_t e;
        cyc  = 0;
        hs   = 0;
        done = 1'b0;
        while (!done && hs < max_hs && cyc < 200) begin
            s_axi_rready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (s_axi_rvalid) begin
                chk("arready_busy", 64'(s_axi_arready), 64'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(s_axi_rvalid), 64'd0);
                end else begin
                    e = exp_q[0];
                    if (s_axi_rready) begin
                        void'(exp_q.pop_front());
                        chk("rdata", s_axi_rdata, e.data);
                        chk("rresp", 64'(s_axi_rresp), 64'(e.resp));
                        chk("rlast", 64'(s_axi_rlast), 64'(e.last));
                        hs++;
                        done = e.last;
                    end else begin
                        chk("rdata_held", s_axi_rdata, e.data);
                        chk("rlast_held", 64'(s_axi_rlast), 64'(e.last));
                    end
                end
            end
            cyc++;
            @(negedge clock);
        end
        s_axi_rready = 1'b0;
        chk("burst_progress", 64'(done || hs == max_hs), 64'd1);
    endtask

    task automatic idle_chk();
        chk("idle_arready", 64'(s_axi_arready), 64'd1);
        chk("idle_rvalid", 64'(s_axi_rvalid), 64'd0);
    endtask

    initial begin
        #12;
        chk("rst_arready", 64'(s_axi_arready), 64'd1);
        chk("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
        chk("rst_rlast", 64'(s_axi_rlast), 64'd0);
        chk("rst_rresp", 64'(s_axi_rresp), 64'd0);
        chk("rst_rdata", s_axi_rdata, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int k = 0; k < MEM_WORDS; k++) begin
            @(negedge clock);
            mem_we    = 1'b1;
            mem_waddr = 64'(k) * 64'd8;
            mem_wdata = 64'h1000 + 64'(k);
            shadow[k] = 64'h1000 + 64'(k);
        end
        @(negedge clock);
        mem_waddr = MEM_BYTES;
        mem_wdata = 64'hDEAD;
        @(negedge clock);
        mem_we = 1'b0;

        send_ar(64'h28, 8'd7, 3'd3, 2'd2);
        collect(0, 255);
        idle_chk();

        send_ar(64'h28, 8'd7, 3'd3, 2'd2);
        collect(1, 255);
        idle_chk();

        send_ar(64'h10, 8'd0, 3'd3, 2'd1);
        collect(0, 255);
        send_ar(64'h8, 8'd3, 3'd3, 2'd0);
        collect(1, 255);
        send_ar(64'h4, 8'd3, 3'd2, 2'd1);
        collect(0, 255);

        send_ar(MEM_BYTES - 64'd16, 8'd3, 3'd3, 2'd1);
        collect(0, 255);
        send_ar(64'h40, 8'd2, 3'd3, 2'd2);
        collect(0, 255);
        send_ar(64'h0, 8'd1, 3'd4, 2'd1);
        collect(0, 255);
        send_ar(64'h0, 8'd0, 3'd3, 2'd3);
        collect(0, 255);
        idle_chk();

        // Preload word 1 while beat 2 is stalled; beat 5 of this WRAP reads word 1.
        shadow[1] = 64'hBEEF_0001;
        send_ar(64'h28, 8'd7, 3'd3, 2'd2);
        collect(0, 1);
        mem_we    = 1'b1;
        mem_waddr = 64'h8;
        mem_wdata = 64'hBEEF_0001;
        @(negedge clock);
        mem_we = 1'b0;
        collect(0, 255);
        idle_chk();

        send_ar(64'h0, 8'd7, 3'd3, 2'd1);
        collect(0, 3);
        chk("pre_reset_rvalid", 64'(s_axi_rvalid), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", 64'(s_axi_rvalid), 64'd0);
        chk("mid_rst_arready", 64'(s_axi_arready), 64'd1);
        chk("mid_rst_rlast", 64'(s_axi_rlast), 64'd0);
        chk("mid_rst_rdata", s_axi_rdata, 64'd0);
        chk("mid_rst_rresp", 64'(s_axi_rresp), 64'd0);
        exp_q.delete();
        @(negedge clock);
        reset_n = 1'b1;
        send_ar(64'h18, 8'd1, 3'd3, 2'd1);
        collect(1, 255);
        idle_chk();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
